grid_cursor_ctrl: RTL and testbench

Parametrised arrow-key front end for the VGA game: converts raw push-button keys into debounced-by-edge, auto-repeating step events and applies them either to a ROWS x COLS grid cursor or to a saturating level selector, depending on the current game input state. Sits between the board key inputs and the VGA renderer / game FSM, and replaces the fixed 6x6, no-repeat cursor logic.

---
 rtl/grid_cursor_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_grid_cursor_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_cursor_ctrl.sv
// grid_cursor_ctrl: arrow-key front end for the VGA game.
// Synchronizes raw buttons, turns a single held arrow key into an initial
// step event plus timed auto-repeat events, and applies those events to a
// ROWS x COLS grid cursor (grid play) or a saturating level selector
// (level select).
//
// Repeat FSM
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no valid key held; next valid key fires an event at once
//   ST_HOLD   | key held, counting down REPEAT_DELAY to the first repeat
//   ST_REPEAT | key still held, firing an event every REPEAT_PERIOD cycles
module grid_cursor_ctrl #(
  parameter int ROWS          = 6,
  parameter int COLS          = 6,
  parameter int LEVELS        = 4,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            A,
  input  logic [3:0]                      keys,
  input  logic [2:0]                      inputState,
  output logic [$clog2(ROWS*COLS)-1:0]    cursor,
  output logic [$clog2(ROWS)-1:0]         row,
  output logic [$clog2(COLS)-1:0]         col,
  output logic [$clog2(LEVELS+1)-1:0]     level_pending,
  output logic [$clog2(LEVELS+1)-1:0]     level,
  output logic                            move_pulse,
  output logic                            select_pulse
);

  localparam int CW   = $clog2(ROWS*COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int KW   = $clog2(COLS);
  localparam int LW   = $clog2(LEVELS+1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNTW = $clog2(RMAX+1);

  // Loads are one less than the interval: the count reaches zero on the
  // cycle whose edge must register the next event.
  localparam logic [CNTW-1:0] DLY_LOAD = CNTW'(REPEAT_DELAY-1);
  localparam logic [CNTW-1:0] PER_LOAD = CNTW'(REPEAT_PERIOD-1);
  localparam logic [RW-1:0]   ROW_MAX  = RW'(ROWS-1);
  localparam logic [KW-1:0]   COL_MAX  = KW'(COLS-1);
  localparam logic [LW-1:0]   LVL_MAX  = LW'(LEVELS);
  localparam logic [LW-1:0]   LVL_MIN  = LW'(1);

  localparam logic [2:0] MODE_LEVEL = 3'd1;
  localparam logic [2:0] MODE_GRID  = 3'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} rep_state_t;

  logic [3:0]      key_s1, key_s2;
  logic            a_s1, a_s2, a_d;
  rep_state_t      state;
  logic [3:0]      held;
  logic [CNTW-1:0] cnt;

  logic            key_valid;
  logic            step;
  logic            a_rise;
  logic [RW-1:0]   row_nx;
  logic [KW-1:0]   col_nx;
  logic [LW-1:0]   lp_nx;

  // Two-flop synchronizers for the buttons, plus one extra A stage for edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
      a_s1   <= 1'b0;
      a_s2   <= 1'b0;
      a_d    <= 1'b0;
    end else begin
      key_s1 <= keys;
      key_s2 <= key_s1;
      a_s1   <= A;
      a_s2   <= a_s1;
      a_d    <= a_s2;
    end
  end

  assign key_valid = $onehot(key_s2);
  assign a_rise    = a_s2 & ~a_d;

  // Step event decode: fresh key, changed key, or repeat timer at terminal count.
  always_comb begin
    step = 1'b0;
    if (key_valid) begin
      if (state == ST_IDLE || key_s2 != held) step = 1'b1;
      else if (cnt == '0)                     step = 1'b1;
    end
  end

  // Repeat FSM with down-counting interval timer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      held  <= '0;
      cnt   <= '0;
    end else if (!key_valid) begin
      state <= ST_IDLE;
      held  <= '0;
      cnt   <= '0;
    end else if (state == ST_IDLE || key_s2 != held) begin
      state <= ST_HOLD;
      held  <= key_s2;
      cnt   <= DLY_LOAD;
    end else if (cnt == '0) begin
      state <= ST_REPEAT;
      cnt   <= PER_LOAD;
    end else begin
      cnt   <= cnt - 1'b1;
    end
  end

  // Next grid position for this cycle's event; edges either hold or wrap.
  always_comb begin
    row_nx = row;
    col_nx = col;
    if (step) begin
      if (key_s2[0]) begin
        if (row != '0)         row_nx = row - 1'b1;
        else if (WRAP != 0)    row_nx = ROW_MAX;
      end else if (key_s2[1]) begin
        if (row != ROW_MAX)    row_nx = row + 1'b1;
        else if (WRAP != 0)    row_nx = '0;
      end else if (key_s2[2]) begin
        if (col != '0)         col_nx = col - 1'b1;
        else if (WRAP != 0)    col_nx = COL_MAX;
      end else if (key_s2[3]) begin
        if (col != COL_MAX)    col_nx = col + 1'b1;
        else if (WRAP != 0)    col_nx = '0;
      end
    end
  end

  // Next browsed level: up/down saturate at LEVELS and 1, left/right ignored.
  always_comb begin
    lp_nx = level_pending;
    if (step && key_s2[0] && level_pending != LVL_MAX)
      lp_nx = level_pending + 1'b1;
    else if (step && key_s2[1] && level_pending != LVL_MIN)
      lp_nx = level_pending - 1'b1;
  end

  // Output registers; cursor/row/col always load together so they stay consistent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row           <= '0;
      col           <= '0;
      cursor        <= '0;
      level_pending <= LVL_MIN;
      level         <= LVL_MIN;
      move_pulse    <= 1'b0;
      select_pulse  <= 1'b0;
    end else begin
      move_pulse   <= 1'b0;
      select_pulse <= 1'b0;

      if (inputState == MODE_GRID) begin
        row          <= row_nx;
        col          <= col_nx;
        cursor       <= CW'(int'(row_nx) * COLS + int'(col_nx));
        move_pulse   <= (row_nx != row) || (col_nx != col);
        select_pulse <= a_rise;
      end else begin
        row    <= '0;
        col    <= '0;
        cursor <= '0;
      end

      // A commits the value browsed before this cycle's step.
      if (inputState == MODE_LEVEL) begin
        level_pending <= lp_nx;
        move_pulse    <= (lp_nx != level_pending);
        if (a_rise) level <= level_pending;
      end else begin
        level_pending <= level;
      end
    end
  end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Bench for grid_cursor_ctrl: a saturating and a wrapping instance share
// stimulus; a per-edge reference model predicts every output of both.
module tb_grid_cursor_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int LEVELS = 4;
  localparam int DLY = 8;
  localparam int PER = 3;
  localparam int CW = $clog2(ROWS*COLS);
  localparam int RW = $clog2(ROWS);
  localparam int KW = $clog2(COLS);
  localparam int LW = $clog2(LEVELS+1);
  localparam int VW = CW + RW + KW + 2*LW + 2;
  localparam logic [VW-1:0] RST_VEC = {CW'(0), RW'(0), KW'(0), LW'(1), LW'(1), 1'b0, 1'b0};

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic A = 1'b0;
  logic [3:0] keys = 4'b0;
  logic [2:0] inputState = 3'd0;

  logic [CW-1:0] cursor0, cursor1;
  logic [RW-1:0] row0, row1;
  logic [KW-1:0] col0, col1;
  logic [LW-1:0] lp0, lp1, lvl0, lvl1;
  logic mv0, mv1, sel0, sel1;

  always #5 clock = ~clock;

  grid_cursor_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEVELS(LEVELS), .WRAP(0),
                     .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
    .clock(clock), .reset(reset), .A(A), .keys(keys), .inputState(inputState),
    .cursor(cursor0), .row(row0), .col(col0), .level_pending(lp0), .level(lvl0),
    .move_pulse(mv0), .select_pulse(sel0));

  grid_cursor_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEVELS(LEVELS), .WRAP(1),
                     .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_w (
    .clock(clock), .reset(reset), .A(A), .keys(keys), .inputState(inputState),
    .cursor(cursor1), .row(row1), .col(col1), .level_pending(lp1), .level(lvl1),
    .move_pulse(mv1), .select_pulse(sel1));

  int vectors = 0;
  int miscompares = 0;

  // reference model state (index 0 = saturating, 1 = wrapping)
  int m_r[2], m_c[2], m_lp, m_lvl;
  bit m_move[2], m_sel;
  logic [3:0] m_k1, m_k2, m_prev;
  bit m_a1, m_a2, m_ad;
  int m_t;

  int tick_no;
  int pulses[2];
  int first_pulse[2], last_pulse[2];
  int sel_cnt;

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_r[w] = 0; m_c[w] = 0; m_move[w] = 0;
    end
    m_lp = 1; m_lvl = 1; m_sel = 0;
    m_k1 = 0; m_k2 = 0; m_prev = 0; m_t = 0;
    m_a1 = 0; m_a2 = 0; m_ad = 0;
  endtask

  // One clock edge of the behavioural model, using the pre-edge inputs.
  task automatic model_step();
    logic [3:0] p;
    bit ev, arise;
    int nr, nc, nlp;
    p = ($countones(m_k2) == 1) ? m_k2 : 4'b0;
    ev = 0;
    if (p != 0) begin
      if (p == m_prev) m_t++; else m_t = 0;
      ev = (m_t == 0) || (m_t == DLY) || (m_t > DLY && (m_t - DLY) % PER == 0);
    end
    m_prev = p;
    arise = m_a2 && !m_ad;
    for (int w = 0; w < 2; w++) begin
      m_move[w] = 0;
      if (inputState == 3'd2) begin
        nr = m_r[w]; nc = m_c[w];
        if (ev) begin
          if (p[0]) nr = (w == 1) ? (nr + ROWS - 1) % ROWS : (nr > 0 ? nr - 1 : nr);
          if (p[1]) nr = (w == 1) ? (nr + 1) % ROWS : (nr < ROWS - 1 ? nr + 1 : nr);
          if (p[2]) nc = (w == 1) ? (nc + COLS - 1) % COLS : (nc > 0 ? nc - 1 : nc);
          if (p[3]) nc = (w == 1) ? (nc + 1) % COLS : (nc < COLS - 1 ? nc + 1 : nc);
        end
        m_move[w] = (nr != m_r[w]) || (nc != m_c[w]);
        m_r[w] = nr; m_c[w] = nc;
      end else begin
        m_r[w] = 0; m_c[w] = 0;
      end
    end
    if (inputState == 3'd1) begin
      nlp = m_lp;
      if (ev && p[0]) nlp = (m_lp < LEVELS) ? m_lp + 1 : m_lp;
      if (ev && p[1]) nlp = (m_lp > 1) ? m_lp - 1 : m_lp;
      if (nlp != m_lp) begin m_move[0] = 1; m_move[1] = 1; end
      if (arise) m_lvl = m_lp;
      m_lp = nlp;
    end else begin
      m_lp = m_lvl;
    end
    m_sel = (inputState == 3'd2) && arise;
    m_ad = m_a2; m_a2 = m_a1; m_a1 = A;
    m_k2 = m_k1; m_k1 = keys;
  endtask

  function automatic logic [VW-1:0] exp_vec(int w);
    return {CW'(m_r[w] * COLS + m_c[w]), RW'(m_r[w]), KW'(m_c[w]),
            LW'(m_lp), LW'(m_lvl), m_move[w], m_sel};
  endfunction

  function automatic logic [VW-1:0] got_vec(int w);
    if (w == 0) return {cursor0, row0, col0, lp0, lvl0, mv0, sel0};
    return {cursor1, row1, col1, lp1, lvl1, mv1, sel1};
  endfunction

  // Advance one edge, step the model, compare both instances against it.
  task automatic tick();
    logic [VW-1:0] g, e;
    @(posedge clock);
    if (reset) model_reset(); else model_step();
    #1;
    tick_no++;
    for (int w = 0; w < 2; w++) begin
      g = got_vec(w); e = exp_vec(w);
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL model_wrap%0d t=%0t {cursor,row,col,lp,lvl,move,sel} got=%h exp=%h",
                 w, $time, g, e);
      end
    end
    if (mv0) begin pulses[0]++; if (first_pulse[0] < 0) first_pulse[0] = tick_no; last_pulse[0] = tick_no; end
    if (mv1) begin pulses[1]++; if (first_pulse[1] < 0) first_pulse[1] = tick_no; last_pulse[1] = tick_no; end
    if (sel0) sel_cnt++;
  endtask

  task automatic clear_counts();
    tick_no = 0; sel_cnt = 0;
    for (int w = 0; w < 2; w++) begin
      pulses[w] = 0; first_pulse[w] = -1; last_pulse[w] = -1;
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(logic [3:0] k, int hold, int gap);
    keys = k;
    ticks(hold);
    keys = 4'b0;
    ticks(gap);
  endtask

  task automatic do_reset();
    keys = 4'b0; A = 1'b0;
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      vectors++;
      if (got_vec(w) !== RST_VEC) begin
        miscompares++;
        $display("FAIL reset_values wrap%0d got=%h exp=%h", w, got_vec(w), RST_VEC);
      end
    end
    model_reset();
    ticks(2);
    reset = 1'b0;
    ticks(2);
  endtask

  task automatic test_grid_saturate();
    do_reset();
    inputState = 3'd2;
    ticks(1);
    clear_counts();
    for (int i = 0; i < 5; i++) press(4'b1000, 2, 3);
    vectors++;
    if (col0 !== KW'(4) || cursor0 !== CW'(4) || pulses[0] != 4) begin
      miscompares++;
      $display("FAIL right_x5 col=%0d cursor=%0d pulses=%0d exp col=4 cursor=4 pulses=4",
               col0, cursor0, pulses[0]);
    end
    vectors++;
    if (col1 !== KW'(0) || pulses[1] != 5) begin
      miscompares++;
      $display("FAIL right_x5_wrap col=%0d pulses=%0d exp col=0 pulses=5", col1, pulses[1]);
    end
    clear_counts();
    for (int i = 0; i < 3; i++) press(4'b0010, 2, 3);
    vectors++;
    if (row0 !== RW'(3) || cursor0 !== CW'(19) || pulses[0] != 3) begin
      miscompares++;
      $display("FAIL down_x3 row=%0d cursor=%0d pulses=%0d exp row=3 cursor=19 pulses=3",
               row0, cursor0, pulses[0]);
    end
    clear_counts();
    press(4'b0010, 2, 3);
    vectors++;
    if (row0 !== RW'(3) || cursor0 !== CW'(19) || pulses[0] != 0) begin
      miscompares++;
      $display("FAIL down_blocked row=%0d cursor=%0d pulses=%0d exp row=3 cursor=19 pulses=0",
               row0, cursor0, pulses[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    inputState = 3'd2;
    ticks(1);
    press(4'b0001, 2, 3);
    vectors++;
    if (row1 !== RW'(3) || cursor1 !== CW'(15) || row0 !== RW'(0)) begin
      miscompares++;
      $display("FAIL wrap_up row=%0d cursor=%0d sat_row=%0d exp row=3 cursor=15 sat_row=0",
               row1, cursor1, row0);
    end
    press(4'b0100, 2, 3);
    vectors++;
    if (col1 !== KW'(4) || cursor1 !== CW'(19)) begin
      miscompares++;
      $display("FAIL wrap_left col=%0d cursor=%0d exp col=4 cursor=19", col1, cursor1);
    end
    clear_counts();
    press(4'b0011, 6, 3);
    vectors++;
    if (pulses[1] != 0 || cursor1 !== CW'(19)) begin
      miscompares++;
      $display("FAIL multi_key pulses=%0d cursor=%0d exp pulses=0 cursor=19", pulses[1], cursor1);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    inputState = 3'd2;
    ticks(1);
    clear_counts();
    press(4'b1000, 22, 4);
    vectors++;
    if (pulses[0] != 4 || first_pulse[0] != 3 || last_pulse[0] != 17 || col0 !== KW'(4)) begin
      miscompares++;
      $display("FAIL repeat_sat pulses=%0d first=%0d last=%0d col=%0d exp 4/3/17/4",
               pulses[0], first_pulse[0], last_pulse[0], col0);
    end
    vectors++;
    if (pulses[1] != 6 || last_pulse[1] != 23 || col1 !== KW'(1)) begin
      miscompares++;
      $display("FAIL repeat_wrap pulses=%0d last=%0d col=%0d exp 6/23/1",
               pulses[1], last_pulse[1], col1);
    end
    clear_counts();
    press(4'b0100, 4, 3);
    vectors++;
    if (first_pulse[0] != 3 || pulses[0] != 1) begin
      miscompares++;
      $display("FAIL repress_after_idle first=%0d pulses=%0d exp 3/1", first_pulse[0], pulses[0]);
    end
  endtask

  task automatic test_level();
    do_reset();
    inputState = 3'd1;
    ticks(1);
    for (int i = 0; i < 5; i++) press(4'b0001, 2, 3);
    vectors++;
    if (lp0 !== LW'(4) || lvl0 !== LW'(1)) begin
      miscompares++;
      $display("FAIL level_up lp=%0d lvl=%0d exp lp=4 lvl=1", lp0, lvl0);
    end
    A = 1'b1;
    ticks(2);
    vectors++;
    if (lvl0 !== LW'(1)) begin
      miscompares++;
      $display("FAIL level_early lvl=%0d exp 1", lvl0);
    end
    ticks(1);
    vectors++;
    if (lvl0 !== LW'(4)) begin
      miscompares++;
      $display("FAIL level_commit lvl=%0d exp 4", lvl0);
    end
    A = 1'b0;
    ticks(2);
    for (int i = 0; i < 5; i++) press(4'b0010, 2, 3);
    vectors++;
    if (lp0 !== LW'(1) || lvl0 !== LW'(4)) begin
      miscompares++;
      $display("FAIL level_down lp=%0d lvl=%0d exp lp=1 lvl=4", lp0, lvl0);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    inputState = 3'd2;
    ticks(1);
    for (int i = 0; i < 3; i++) press(4'b0010, 2, 3);
    for (int i = 0; i < 4; i++) press(4'b1000, 2, 3);
    vectors++;
    if (cursor0 !== CW'(19)) begin
      miscompares++;
      $display("FAIL reach_19 cursor=%0d exp 19", cursor0);
    end
    inputState = 3'd3;
    ticks(1);
    vectors++;
    if (cursor0 !== CW'(0) || cursor1 !== CW'(0)) begin
      miscompares++;
      $display("FAIL idle_clear cursor=%0d/%0d exp 0/0", cursor0, cursor1);
    end
    inputState = 3'd2;
    press(4'b0010, 2, 3);
    clear_counts();
    A = 1'b1;
    ticks(5);
    A = 1'b0;
    ticks(3);
    vectors++;
    if (sel_cnt != 1 || cursor0 !== CW'(COLS)) begin
      miscompares++;
      $display("FAIL select sel_pulses=%0d cursor=%0d exp 1/%0d", sel_cnt, cursor0, COLS);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    inputState = 3'd1;
    press(4'b0001, 2, 3);
    A = 1'b1; ticks(4); A = 1'b0;
    inputState = 3'd2;
    keys = 4'b1000;
    ticks(12);
    #2 reset = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      vectors++;
      if (got_vec(w) !== RST_VEC) begin
        miscompares++;
        $display("FAIL reset_mid_hold wrap%0d got=%h exp=%h", w, got_vec(w), RST_VEC);
      end
    end
    model_reset();
    ticks(2);
    reset = 1'b0;
    clear_counts();
    ticks(6);
    keys = 4'b0;
    ticks(3);
    vectors++;
    if (first_pulse[0] != 3 || pulses[0] != 1) begin
      miscompares++;
      $display("FAIL fresh_after_reset first=%0d pulses=%0d exp 3/1", first_pulse[0], pulses[0]);
    end
  endtask

  task automatic test_random();
    int n, r, hold;
    do_reset();
    n = 0;
    while (n < 3000) begin
      if ($urandom_range(0, 7) == 0) inputState = 3'($urandom_range(0, 4));
      r = $urandom_range(0, 9);
      if (r < 7)      keys = 4'b0001 << $urandom_range(0, 3);
      else if (r < 9) keys = 4'b0;
      else            keys = 4'($urandom);
      hold = $urandom_range(1, 25);
      for (int j = 0; j < hold; j++) begin
        if ($urandom_range(0, 11) == 0) A = ~A;
        tick();
      end
      n += hold;
    end
    keys = 4'b0; A = 1'b0;
    ticks(4);
  endtask

  initial begin
    model_reset();
    clear_counts();
    test_reset();
    test_grid_saturate();
    test_wrap();
    test_repeat();
    test_level();
    test_mode_switch();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
